data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the array; it SHALL be a power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the stall cycles inserted per legal access; its range SHALL be 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-low reset; 0 means in reset.
REQ-005 SHALL have port MemReadM, input, 1 bit: load request from the M stage.
REQ-006 SHALL have port MemWriteM, input, 1 bit: store request from the M stage.
REQ-007 SHALL have port funct3M, input, 3 bits: access size and sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-008 SHALL have port ALUResultM, input, 32 bits: byte address.
REQ-009 SHALL have port WriteDataM, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port ReadDataM, output, 32 bits: extended load data.
REQ-011 SHALL have port StallMem, output, 1 bit: freezes the F/D/E/M registers while high.
REQ-012 SHALL have port MisalignM, output, 1 bit: the current request is misaligned and is ignored.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and DONE, plus a 4-bit down-counter cnt.
REQ-014 A request SHALL mean (MemReadM | MemWriteM) & ~MisalignM; if both MemReadM and MemWriteM are high, the access SHALL be treated as a store, and ReadDataM SHALL be 0.
REQ-015 MisalignM SHALL be combinational: high for an h/hu access with addr[0]=1, or a w access with addr[1:0]!=00; it SHALL be low when no read or write is requested.
REQ-016 A misaligned access SHALL cause no stall, no state change and no array write, and ReadDataM SHALL be 0.
REQ-017 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-018 IDLE with a request and WAIT_CYCLES=0: the access SHALL complete in that cycle, StallMem=0, and the FSM SHALL stay in IDLE.
REQ-019 IDLE with a request and WAIT_CYCLES>=1: StallMem=1; cnt SHALL be loaded with WAIT_CYCLES-1; the next state SHALL be DONE if WAIT_CYCLES=1, else WAIT.
REQ-020 WAIT: StallMem=1 and cnt SHALL decrement; the next state SHALL be DONE when cnt=1, else WAIT.
REQ-021 DONE: StallMem=0 and the access SHALL complete in that cycle; the next state SHALL be IDLE unconditionally.
REQ-022 Total stall per legal access SHALL be exactly WAIT_CYCLES cycles, and the held request SHALL complete in the following cycle.
REQ-023 Completion of a load SHALL drive ReadDataM combinationally from the array: b/h sign-extended, bu/hu zero-extended, byte lane selected by addr[1:0].
REQ-024 Completion of a store SHALL write only the addressed byte lanes (b: 1 lane, h: 2 lanes, w: 4 lanes) at the rising edge ending the completion cycle.
REQ-025 Outside the completion cycle of a load, ReadDataM SHALL be 0.
REQ-026 A request present in the cycle after DONE SHALL be accepted as new, so back-to-back accesses complete every WAIT_CYCLES+1 cycles.
REQ-027 A load completing in the cycle after a store to the same word SHALL return the newly written data.
REQ-028 If a request drops in WAIT (illegal under stall), the FSM SHALL still reach DONE and then IDLE, and SHALL perform no write.
REQ-029 Undefined funct3 values (011, 110, 111) SHALL be treated as w for alignment, load and store purposes.

Reset
REQ-030 When reset=0, state SHALL go to IDLE and cnt to 0 asynchronously, StallMem SHALL be 0, and any in-flight access SHALL be discarded with no write.
REQ-031 The array SHALL NOT be cleared by reset; its contents SHALL persist across reset.
REQ-032 After reset is released, the first request SHALL be handled as a fresh access from IDLE.

Verification
REQ-033 WAIT_CYCLES=2, sw 0xDEADBEEF to 0x10 -> StallMem high 2 cycles then low 1 cycle; the word then reads 0xDEADBEEF.
REQ-034 Word 0x10=0x80FF7F01: lb 0x11 -> 0x0000007F; lb 0x12 -> 0xFFFFFFFF; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF80FF; lhu 0x10 -> 0x00007F01.
REQ-035 lw at 0x06, or sh at 0x03 -> MisalignM=1, StallMem=0, ReadDataM=0, array unchanged.
REQ-036 WAIT_CYCLES=0, sb 0xAB to 0x21 then lw 0x20 in the next cycle -> no stall, read returns byte1=0xAB with the other lanes unchanged.
REQ-037 reset=0 pulsed in WAIT during sw 0x55 to 0x40 -> StallMem drops immediately, word 0x40 unchanged, the next lw 0x40 takes the full WAIT_CYCLES stall.
REQ-038 DEPTH_WORDS=256, sw 0x12345678 to 0x400 -> lw 0x000 returns 0x12345678 (wrap).

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed wait-state handshake for the M stage.
// Legal accesses stall the pipe WAIT_CYCLES cycles, then complete in the cycle after.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        MisalignM
);

  localparam int         AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WC_M1 = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_any, w_req, w_is_h, w_is_w, w_load;
  logic            w_stall, w_complete;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_off;
  logic [31:0]     w_word, w_ext, w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [3:0]      w_be;
  logic            w_unused;

  assign w_off  = ALUResultM[1:0];
  assign w_idx  = ALUResultM[AW+1:2];
  // Upper address bits are deliberately dropped so the array aliases.
  assign w_unused = &{1'b0, ALUResultM[31:AW+2]};

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers the undefined encodings too)
  assign w_is_h = (funct3M[1:0] == 2'b01);
  assign w_is_w = funct3M[1];
  assign w_any  = MemReadM | MemWriteM;
  assign MisalignM = w_any & ((w_is_h & w_off[0]) | (w_is_w & (|w_off)));
  assign w_req  = w_any & ~MisalignM;
  assign w_load = MemReadM & ~MemWriteM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: if (w_req && WAIT_CYCLES != 0) begin
        w_cnt_nxt = WC_M1;
        w_next    = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The request is held by the stall, so completion re-uses the live inputs.
  always_comb begin
    w_stall    = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE: if (w_req) begin
        if (WAIT_CYCLES == 0) w_complete = 1'b1;
        else                  w_stall    = 1'b1;
      end
      S_WAIT:  w_stall    = 1'b1;
      S_DONE:  w_complete = w_req;
      default: ;
    endcase
    w_stall    = w_stall & reset;
    w_complete = w_complete & reset;
  end

  assign StallMem = w_stall;

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ext = w_word;
    if (funct3M[1:0] == 2'b00)
      w_ext = {{24{w_byte[7] & ~funct3M[2]}}, w_byte};
    else if (w_is_h)
      w_ext = {{16{w_half[15] & ~funct3M[2]}}, w_half};
  end

  assign ReadDataM = (w_complete && w_load) ? w_ext : 32'd0;

  always_comb begin
    w_be    = 4'hF;
    w_wdata = WriteDataM;
    if (funct3M[1:0] == 2'b00) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{WriteDataM[7:0]}};
    end else if (w_is_h) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{WriteDataM[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (w_complete && MemWriteM) begin
      for (int l = 0; l < 4; l++)
        if (w_be[l]) r_mem[w_idx][l*8 +: 8] <= w_wdata[l*8 +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with 2 wait states, one with none.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd2, wr2, rd0, wr0;
  logic [2:0]  f32, f30;
  logic [31:0] a2, a0, wd2, wd0;
  logic [31:0] rdata2, rdata0;
  logic        stall2, stall0, mis2, mis0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_slow (
    .clk(clk), .reset(reset), .MemReadM(rd2), .MemWriteM(wr2), .funct3M(f32),
    .ALUResultM(a2), .WriteDataM(wd2), .ReadDataM(rdata2), .StallMem(stall2), .MisalignM(mis2));

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .reset(reset), .MemReadM(rd0), .MemWriteM(wr0), .funct3M(f30),
    .ALUResultM(a0), .WriteDataM(wd0), .ReadDataM(rdata0), .StallMem(stall0), .MisalignM(mis0));

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  typedef struct {
    string       name;
    bit          fast;
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_rd;
    int          exp_stall;
    bit          exp_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    int          stall;
    bit          mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit fast, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (fast) begin rd0 = rd; wr0 = wr; f30 = f3; a0 = addr; wd0 = wd; end
    else      begin rd2 = rd; wr2 = wr; f32 = f3; a2 = addr; wd2 = wd; end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, LW, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, LW, 32'h0, 32'h0);
  endtask

  function automatic vec_t mk(input string nm, input bit fast, input bit rd, input bit wr,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input int exp_stall, input bit exp_mis);
    vec_t v;
    v.name = nm; v.fast = fast; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
    v.wd = wd; v.exp_rd = exp_rd; v.exp_stall = exp_stall; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Drive one access, queue its expectation, count stall cycles, compare at completion.
  task automatic run_vec(input vec_t v);
    int   n;
    bit   done;
    exp_t e;
    logic [31:0] r;
    logic s, m;
    drive(v.fast, v.rd, v.wr, v.f3, v.addr, v.wd);
    sbq.push_back('{v.name, v.exp_rd, v.exp_stall, v.exp_mis});
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      s = v.fast ? stall0 : stall2;
      if (s && n < 40) begin
        n++;
        @(posedge clk); #1;
      end else begin
        r = v.fast ? rdata0 : rdata2;
        m = v.fast ? mis0 : mis2;
        e = sbq.pop_front();
        chk({e.name, ".rdata"}, r, e.rd);
        chk({e.name, ".stall_cycles"}, 32'(n), 32'(e.stall));
        chk({e.name, ".misalign"}, {31'd0, m}, {31'd0, e.mis});
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  initial begin
    reset = 1'b0;
    idle_all();
    drive(1'b0, 1'b1, 1'b0, LW, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, LW, 32'h10, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.slow_stall", {31'd0, stall2}, 32'd0);
    chk("reset.slow_rdata", rdata2, 32'd0);
    chk("reset.fast_rdata", rdata0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, LW, 32'h3, 32'h0);
    @(negedge clk);
    chk("noreq.misalign_low", {31'd0, mis2}, 32'd0);
    chk("noreq.stall_low", {31'd0, stall2}, 32'd0);
    @(posedge clk); #1;

    vecs.push_back(mk("sw_dead",   0, 0, 1, LW,  32'h10,  32'hDEADBEEF, 32'h0,        2, 0));
    vecs.push_back(mk("lw_dead",   0, 1, 0, LW,  32'h10,  32'h0,        32'hDEADBEEF, 2, 0));
    vecs.push_back(mk("sw_mix",    0, 0, 1, LW,  32'h10,  32'h80FF7F01, 32'h0,        2, 0));
    vecs.push_back(mk("lb_11",     0, 1, 0, LB,  32'h11,  32'h0,        32'h0000007F, 2, 0));
    vecs.push_back(mk("lb_12",     0, 1, 0, LB,  32'h12,  32'h0,        32'hFFFFFFFF, 2, 0));
    vecs.push_back(mk("lbu_13",    0, 1, 0, LBU, 32'h13,  32'h0,        32'h00000080, 2, 0));
    vecs.push_back(mk("lh_12",     0, 1, 0, LH,  32'h12,  32'h0,        32'hFFFF80FF, 2, 0));
    vecs.push_back(mk("lhu_10",    0, 1, 0, LHU, 32'h10,  32'h0,        32'h00007F01, 2, 0));
    vecs.push_back(mk("lw_f3_011", 0, 1, 0, 3'b011, 32'h10, 32'h0,      32'h80FF7F01, 2, 0));
    vecs.push_back(mk("sw_wrap",   0, 0, 1, LW,  32'h400, 32'h12345678, 32'h0,        2, 0));
    vecs.push_back(mk("lw_wrap",   0, 1, 0, LW,  32'h0,   32'h0,        32'h12345678, 2, 0));
    vecs.push_back(mk("lw_mis06",  0, 1, 0, LW,  32'h06,  32'h0,        32'h0,        0, 1));
    vecs.push_back(mk("sh_mis03",  0, 0, 1, LH,  32'h03,  32'h0000BEEF, 32'h0,        0, 1));
    vecs.push_back(mk("f3_111_mis",0, 1, 0, 3'b111, 32'h12, 32'h0,      32'h0,        0, 1));
    vecs.push_back(mk("lw_postmis",0, 1, 0, LW,  32'h0,   32'h0,        32'h12345678, 2, 0));
    vecs.push_back(mk("rw_both",   0, 1, 1, LW,  32'h20,  32'hCAFEF00D, 32'h0,        2, 0));
    vecs.push_back(mk("lw_both",   0, 1, 0, LW,  32'h20,  32'h0,        32'hCAFEF00D, 2, 0));
    vecs.push_back(mk("sb_22",     0, 0, 1, LB,  32'h22,  32'hFFFFFF5A, 32'h0,        2, 0));
    vecs.push_back(mk("lw_sb22",   0, 1, 0, LW,  32'h20,  32'h0,        32'hCA5AF00D, 2, 0));
    vecs.push_back(mk("sh_20",     0, 0, 1, LH,  32'h20,  32'hFFFF9999, 32'h0,        2, 0));
    vecs.push_back(mk("lw_sh20",   0, 1, 0, LW,  32'h20,  32'h0,        32'hCA5A9999, 2, 0));
    vecs.push_back(mk("lhu_22",    0, 1, 0, LHU, 32'h22,  32'h0,        32'h0000CA5A, 2, 0));
    vecs.push_back(mk("lh_20",     0, 1, 0, LH,  32'h20,  32'h0,        32'hFFFF9999, 2, 0));
    vecs.push_back(mk("sw_40",     0, 0, 1, LW,  32'h40,  32'hA5A5A5A5, 32'h0,        2, 0));
    vecs.push_back(mk("sw_44",     0, 0, 1, LW,  32'h44,  32'h0BADF00D, 32'h0,        2, 0));
    vecs.push_back(mk("f_sw20",    1, 0, 1, LW,  32'h20,  32'h44332211, 32'h0,        0, 0));
    vecs.push_back(mk("f_sb21",    1, 0, 1, LB,  32'h21,  32'h000000AB, 32'h0,        0, 0));
    vecs.push_back(mk("f_lw20",    1, 1, 0, LW,  32'h20,  32'h0,        32'h4433AB11, 0, 0));
    vecs.push_back(mk("f_lh_mis",  1, 1, 0, LH,  32'h21,  32'h0,        32'h0,        0, 1));
    vecs.push_back(mk("f_lbu21",   1, 1, 0, LBU, 32'h21,  32'h0,        32'h000000AB, 0, 0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulsed while a store is waiting: no write, immediate stall release.
    drive(1'b0, 1'b0, 1'b1, LW, 32'h40, 32'h00000055);
    @(negedge clk);
    chk("rstwait.idle_stall", {31'd0, stall2}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstwait.wait_stall", {31'd0, stall2}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rstwait.async_stall", {31'd0, stall2}, 32'd0);
    chk("rstwait.rdata", rdata2, 32'd0);
    idle_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_vec(mk("rstwait.lw40", 0, 1, 0, LW, 32'h40, 32'h0, 32'hA5A5A5A5, 2, 0));
    run_vec(mk("rstwait.fast_persist", 1, 1, 0, LW, 32'h20, 32'h0, 32'h4433AB11, 0, 0));

    // Request withdrawn during WAIT: FSM still runs out, nothing written.
    drive(1'b0, 1'b0, 1'b1, LW, 32'h44, 32'h77777777);
    @(negedge clk);
    chk("drop.idle_stall", {31'd0, stall2}, 32'd1);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    chk("drop.wait_stall", {31'd0, stall2}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop.done_stall", {31'd0, stall2}, 32'd0);
    @(posedge clk); #1;
    run_vec(mk("drop.lw44", 0, 1, 0, LW, 32'h44, 32'h0, 32'h0BADF00D, 2, 0));

    chk("scoreboard.empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
